// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared state encoding and line-count derivation for the decoder scan sequencer.
// Latency: n/a (constants only). Backpressure: n/a.
package decoder_scan_sequencer_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] DWELL = 2'd2;

    function automatic int n_lines(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage

// File: rtl/decoder_scan_sequencer_next_line_finder.sv
// Finds the lowest set mask bit strictly above cur, or the lowest set bit overall when from_start.
// Latency: combinational. Backpressure: none; wrap=1 when no such bit exists.
module next_line_finder
    import decoder_scan_sequencer_pkg::*;
#(
    parameter int SEL_W = 3,
    localparam int N_LINES = n_lines(SEL_W)
) (
    input  logic [N_LINES-1:0] mask,
    input  logic [SEL_W-1:0]   cur,
    input  logic               from_start,
    output logic [SEL_W-1:0]   nxt,
    output logic               wrap
);

    // Descending scan so the last hit written is the lowest qualifying index.
    always_comb begin
        nxt  = '0;
        wrap = 1'b1;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || ((SEL_W+1)'(i) > {1'b0, cur}))) begin
                nxt  = i[SEL_W-1:0];
                wrap = 1'b0;
            end
        end
    end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Steps a registered decoder select through the enabled lines: blank interval, then dwell with en high.
// Latency: busy/sel one cycle after start; en rises BLANK_CYCLES later. Backpressure: none; stop halts at dwell end.
module decoder_scan_sequencer
    import decoder_scan_sequencer_pkg::*;
#(
    parameter int SEL_W        = 3,
    parameter int DWELL_CYCLES = 16,
    parameter int BLANK_CYCLES = 2,
    localparam int N_LINES = n_lines(SEL_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               continuous,
    input  logic               stop,
    input  logic [N_LINES-1:0] line_mask,
    output logic [SEL_W-1:0]   sel,
    output logic               en,
    output logic               busy,
    output logic               frame_done
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [N_LINES-1:0] mask_q;
    logic               stop_req_q;

    logic [SEL_W-1:0]   step_nxt, first_nxt, sel_d;
    logic               step_wrap, first_wrap;
    logic               en_d, busy_d, frame_done_d;

    next_line_finder #(.SEL_W(SEL_W)) u_step (
        .mask       (mask_q),
        .cur        (sel),
        .from_start (1'b0),
        .nxt        (step_nxt),
        .wrap       (step_wrap)
    );

    // Lowest line of the live mask, used at every latch point.
    next_line_finder #(.SEL_W(SEL_W)) u_first (
        .mask       (line_mask),
        .cur        ('0),
        .from_start (1'b1),
        .nxt        (first_nxt),
        .wrap       (first_wrap)
    );

    logic cnt_done, dwell_end, stop_eff, load_first, load_next;

    assign cnt_done   = (cnt_q == CW'(1));
    assign dwell_end  = (state_q == DWELL) && cnt_done;
    assign stop_eff   = stop_req_q || stop;
    assign load_next  = dwell_end && !step_wrap && !stop_eff;
    assign load_first = !first_wrap &&
                        (((state_q == IDLE) && start) ||
                         (dwell_end && step_wrap && continuous && !stop_eff));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mask_q     <= '0;
            stop_req_q <= 1'b0;
            sel        <= '0;
            en         <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel        <= sel_d;
            en         <= en_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
            if (load_first) begin
                mask_q <= line_mask;
            end
            if (state_d != state_q || load_next || load_first) begin
                cnt_q <= (state_d == DWELL) ? CW'(DWELL_CYCLES) : CW'(BLANK_CYCLES);
            end else if (state_q != IDLE) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (state_d == IDLE) begin
                stop_req_q <= 1'b0;
            end else if (state_q != IDLE && stop) begin
                stop_req_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_first) state_d = BLANK;
            BLANK:   if (cnt_done) state_d = DWELL;
            DWELL:   if (dwell_end) state_d = (load_first || load_next) ? BLANK : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d        = sel;
        if (load_first) begin
            sel_d = first_nxt;
        end else if (load_next) begin
            sel_d = step_nxt;
        end
        frame_done_d = dwell_end && step_wrap;
        en_d         = (state_d == DWELL);
        busy_d       = (state_d != IDLE);
    end

endmodule
